// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits MSB first, optional even parity, stop bit.
// Each bit is held for OVERSAMPLE clocks; the serial line and status outputs are registered.
module uart_tx #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 1
) (
    input  logic       tx_clk,
    input  logic       tx_rst,
    input  logic       tx_en,
    input  logic [7:0] tx_i_data,
    input  logic       tx_i_data_valid,
    output logic       tx_o_ready,
    output logic       o_tx,
    output logic       tx_o_busy,
    output logic       tx_o_done
);

    localparam int unsigned SubW = $clog2(OVERSAMPLE);
    localparam logic [SubW-1:0] SubLast = SubW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e          state_q;
    logic [SubW-1:0] sub_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            par_q;
    logic            tx_q;
    logic            tx_d;
    logic            busy_q;
    logic            end_q;
    logic            done_q;

    logic bit_end;
    logic stop_end;
    logic accept;

    assign bit_end    = (sub_q == SubLast);
    assign stop_end   = (state_q == StStop) && bit_end;
    // Ready in the final stop clock lets the next frame start with no idle gap.
    assign tx_o_ready = tx_en && !tx_rst && ((state_q == StIdle) || stop_end);
    assign accept     = tx_i_data_valid && tx_o_ready;

    assign o_tx      = tx_q;
    assign tx_o_busy = busy_q;
    assign tx_o_done = done_q;

    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_q[7];
            StParity: tx_d = par_q;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge tx_clk) begin
        if (tx_rst || !tx_en) begin
            state_q <= StIdle;
            sub_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            end_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            busy_q <= (state_q != StIdle);
            // Done lags the stop-bit end by one more clock to line up with the registered line.
            end_q  <= stop_end;
            done_q <= end_q;
            if (accept) begin
                state_q <= StStart;
                sub_q   <= '0;
                shift_q <= tx_i_data;
                par_q   <= ^tx_i_data;
            end else if (state_q != StIdle) begin
                sub_q <= bit_end ? '0 : sub_q + SubW'(1);
                if (bit_end) begin
                    case (state_q)
                        StStart: begin
                            state_q <= StData;
                            bit_q   <= '0;
                        end
                        StData: begin
                            shift_q <= {shift_q[6:0], 1'b0};
                            bit_q   <= bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                state_q <= (PARITY_EN != 0) ? StParity : StStop;
                            end
                        end
                        StParity: state_q <= StStop;
                        default:  state_q <= StIdle;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (16x with parity, 4x without) checked against a
// per-clock frame model built from bit position arithmetic.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ready_a, tx_a, busy_a, done_a;
    logic       ready_b, tx_b, busy_b, done_b;
    int         checks = 0;
    int         passed = 0;

    always #5 clk = ~clk;

    uart_tx #(.OVERSAMPLE(16), .PARITY_EN(1)) dut_a (
        .tx_clk(clk), .tx_rst(rst), .tx_en(en), .tx_i_data(data_a),
        .tx_i_data_valid(valid_a), .tx_o_ready(ready_a), .o_tx(tx_a),
        .tx_o_busy(busy_a), .tx_o_done(done_a)
    );

    uart_tx #(.OVERSAMPLE(4), .PARITY_EN(0)) dut_b (
        .tx_clk(clk), .tx_rst(rst), .tx_en(en), .tx_i_data(data_b),
        .tx_i_data_valid(valid_b), .tx_o_ready(ready_b), .o_tx(tx_b),
        .tx_o_busy(busy_b), .tx_o_done(done_b)
    );

    // Line value c clocks into a frame: slot 0 start, 1..8 data MSB first, then parity/stop.
    function automatic logic ref_bit(input logic [7:0] b, input int os, input bit pe, input int c);
        int idx;
        idx = c / os;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[8-idx];
        if (pe && idx == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic accept(input bit which, input logic [7:0] b, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if ((which ? ready_b : ready_a) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            $display("FAIL accept_timeout: ready got 0 want 1");
            return;
        end
        if (which) begin data_b = b; valid_b = 1'b1; end
        else begin data_a = b; valid_a = 1'b1; end
        @(posedge clk); #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        data_a = 8'($urandom);
        data_b = 8'($urandom);
    endtask

    // Called just after the accept edge; checks the whole frame, done pulse and busy fall.
    task automatic capture(input bit which, input logic [7:0] b, input string name);
        int os, len;
        bit pe, busy_ok, early;
        logic [175:0] got, exp;
        logic [7:0] rx;
        os = which ? 4 : 16;
        pe = !which;
        len = os * (pe ? 11 : 10);
        busy_ok = 1'b1;
        early = 1'b0;
        got = '0;
        exp = '0;
        @(negedge clk);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            got[c] = which ? tx_b : tx_a;
            exp[c] = ref_bit(b, os, pe, c);
            if ((which ? busy_b : busy_a) !== 1'b1) busy_ok = 1'b0;
            if ((which ? done_b : done_a) !== 1'b0) early = 1'b1;
        end
        checks++;
        if (got !== exp) $display("FAIL %s_line: got %h want %h", name, got, exp);
        else passed++;
        checks++;
        if (!busy_ok || early)
            $display("FAIL %s_in_frame: busy_ok=%0d early_done=%0d want 1 0", name, busy_ok, early);
        else passed++;
        @(negedge clk);
        checks++;
        if ((which ? {done_b, busy_b, tx_b} : {done_a, busy_a, tx_a}) !== 3'b101)
            $display("FAIL %s_end: done/busy/tx got %b want 101", name,
                     which ? {done_b, busy_b, tx_b} : {done_a, busy_a, tx_a});
        else passed++;
        @(negedge clk);
        checks++;
        if ((which ? done_b : done_a) !== 1'b0)
            $display("FAIL %s_done_width: done got 1 want 0", name);
        else passed++;
        if (which) begin
            for (int k = 0; k < 8; k++) rx[7-k] = got[(k + 1) * os + os / 2];
            checks++;
            if (rx !== b || got[os/2] !== 1'b0 || got[9*os+os/2] !== 1'b1)
                $display("FAIL %s_loopback: got %h want %h", name, rx, b);
            else passed++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({tx_a, busy_a, done_a, ready_a, tx_b, busy_b, done_b, ready_b} !== 8'b1000_1000)
            $display("FAIL reset_state: got %b want 10001000",
                     {tx_a, busy_a, done_a, ready_a, tx_b, busy_b, done_b, ready_b});
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({ready_a, ready_b} !== 2'b11) $display("FAIL reset_release_ready: got %b want 11",
                                                   {ready_a, ready_b});
        else passed++;
    endtask

    task automatic test_frames();
        bit ok;
        logic [7:0] b;
        accept(1'b0, 8'hA5, ok);
        if (ok) capture(1'b0, 8'hA5, "frame_a5");
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            accept(1'b0, b, ok);
            if (ok) capture(1'b0, b, "frame_rand");
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [351:0] got, exp;
        int ready_cnt, done_cnt, done_at;
        bit busy_ok, ready_174;
        accept(1'b0, 8'h01, ok);
        if (!ok) return;
        // Re-offer immediately and keep valid high so the second byte waits on ready.
        data_a = 8'hFF;
        valid_a = 1'b1;
        ready_cnt = 0; done_cnt = 0; done_at = -1; busy_ok = 1'b1; ready_174 = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 352; c++) begin
            @(negedge clk);
            got[c] = tx_a;
            exp[c] = (c < 176) ? ref_bit(8'h01, 16, 1'b1, c) : ref_bit(8'hFF, 16, 1'b1, c - 176);
            if (c < 176 && ready_a === 1'b1) ready_cnt++;
            if (c == 174) ready_174 = ready_a;
            if (c == 175) valid_a = 1'b0;
            if (busy_a !== 1'b1) busy_ok = 1'b0;
            if (done_a === 1'b1) begin done_cnt++; done_at = c; end
        end
        checks++;
        if (got !== exp) $display("FAIL b2b_line: got %h want %h", got, exp);
        else passed++;
        checks++;
        if (ready_cnt != 1 || ready_174 !== 1'b1)
            $display("FAIL b2b_ready: count %0d at174 %b want 1 1", ready_cnt, ready_174);
        else passed++;
        checks++;
        if (done_cnt != 1 || done_at != 176 || !busy_ok)
            $display("FAIL b2b_done_busy: done_cnt %0d at %0d busy_ok %0d want 1 176 1",
                     done_cnt, done_at, busy_ok);
        else passed++;
        @(negedge clk);
        checks++;
        if ({done_a, busy_a, tx_a} !== 3'b101)
            $display("FAIL b2b_end: got %b want 101", {done_a, busy_a, tx_a});
        else passed++;
    endtask

    task automatic test_ignore_busy();
        bit ok;
        logic [7:0] b;
        int when;
        b = 8'($urandom);
        when = $urandom_range(10, 160);
        accept(1'b0, b, ok);
        if (!ok) return;
        fork
            capture(1'b0, b, "busy_ign");
            begin
                repeat (when) @(negedge clk);
                data_a = 8'h33;
                valid_a = 1'b1;
                @(negedge clk);
                valid_a = 1'b0;
            end
        join
        repeat (10) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) $display("FAIL busy_ign_late: busy got %b want 0", busy_a);
        else passed++;
    endtask

    task automatic test_enable_abort();
        bit ok, done_seen;
        accept(1'b0, 8'hC3, ok);
        if (!ok) return;
        @(negedge clk);
        repeat (70) @(negedge clk);
        checks++;
        if (tx_a !== ref_bit(8'hC3, 16, 1'b1, 69))
            $display("FAIL abort_bit3: got %b want %b", tx_a, ref_bit(8'hC3, 16, 1'b1, 69));
        else passed++;
        en = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_a, busy_a, done_a, ready_a} !== 4'b1000)
            $display("FAIL abort_state: got %b want 1000", {tx_a, busy_a, done_a, ready_a});
        else passed++;
        done_seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (done_a !== 1'b0 || tx_a !== 1'b1) done_seen = 1'b1;
        end
        checks++;
        if (done_seen) $display("FAIL abort_quiet: activity got 1 want 0");
        else passed++;
        en = 1'b1;
        accept(1'b0, 8'h5A, ok);
        if (ok) capture(1'b0, 8'h5A, "after_abort");
    endtask

    task automatic test_reset_parity();
        bit ok;
        logic [7:0] b;
        b = 8'($urandom);
        accept(1'b0, b, ok);
        if (!ok) return;
        @(negedge clk);
        repeat (150) @(negedge clk);
        checks++;
        if (tx_a !== ^b) $display("FAIL rst_parity_bit: got %b want %b", tx_a, ^b);
        else passed++;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({tx_a, busy_a, done_a, ready_a} !== 4'b1000)
                $display("FAIL rst_parity_held: got %b want 1000", {tx_a, busy_a, done_a, ready_a});
            else passed++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({ready_a, busy_a, tx_a} !== 3'b101)
            $display("FAIL rst_parity_release: got %b want 101", {ready_a, busy_a, tx_a});
        else passed++;
    endtask

    task automatic test_no_parity();
        bit ok;
        logic [7:0] b;
        accept(1'b1, 8'h80, ok);
        if (ok) capture(1'b1, 8'h80, "np_80");
        b = 8'($urandom);
        accept(1'b1, b, ok);
        if (ok) capture(1'b1, b, "np_rand");
    endtask

    initial begin
        rst = 1'b1; en = 1'b0;
        valid_a = 1'b0; valid_b = 1'b0;
        data_a = '0; data_b = '0;
        test_reset();
        test_frames();
        test_back_to_back();
        test_ignore_busy();
        test_enable_abort();
        test_reset_parity();
        test_no_parity();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
